crc_stream: RTL and testbench
=============================

CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 Parameter CRC_W, default 8, CRC width in bits; legal values are 8, 16, 24 or 32.
REQ-002 Parameter POLY, default 8'h07, generator polynomial, normal form, implicit top bit.
REQ-003 Parameter INIT, default 0, CRC register value at frame start.
REQ-004 Parameter XOR_OUT, default 0, value XORed onto the final CRC.
REQ-005 Parameter REFLECT, default 0, where 1 means LSB-first data in, reflected CRC out, and CRC bytes sent least-significant byte first.
REQ-006 Port clk, input, 1 bit, sole clock with all logic on its rising edge.
REQ-007 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 Port s_valid / s_ready, input / output, 1 bit each, input byte handshake.
REQ-009 Port s_data, input, 8 bits, frame byte.
REQ-010 Port s_last, input, 1 bit, marks the final byte of the frame.
REQ-011 Port m_valid / m_ready, output / input, 1 bit each, output byte handshake.
REQ-012 Port m_data, output, 8 bits, output byte.
REQ-013 Port m_last, output, 1 bit, marks the final output byte of the frame.

Function
REQ-014 A transfer occurs on any edge where valid and ready are both high.
- Once m_valid is asserted, m_data and m_last shall hold until the edge where m_ready is high.
REQ-015 The output is a single register stage.
- An accepted input byte appears on m_data on the next cycle.
REQ-016 s_ready shall be high only when the state is PASS and the output register can load (!m_valid || m_ready).
REQ-017 The FSM has two states, PASS and APPEND.
- PASS -> APPEND on acceptance of a byte with s_last=1.
- APPEND -> PASS when the last CRC byte is loaded into the output register.
REQ-018 In PASS, each accepted byte is forwarded unchanged with m_last=0.
REQ-019 In PASS, each accepted byte updates the CRC register as crc <= crc_next(crc, s_data).
REQ-020 The CRC register is loaded with INIT after each APPEND -> PASS transition and after reset.
- The first byte of every frame is therefore folded into INIT.
REQ-021 In APPEND, the block emits CRC_W/8 bytes of (crc ^ XOR_OUT) on successive output handshakes.
- Byte order is MSB byte first when REFLECT=0 and LSB byte first when REFLECT=1.
- m_last=1 is set on the final CRC byte only.
REQ-022 Stalls in APPEND (m_ready=0) shall not advance the CRC byte index or alter the CRC value.
REQ-023 A single-byte frame (s_last on the first byte) is legal and produces 1+CRC_W/8 output bytes.
REQ-024 Back-to-back frames: the first byte of the next frame may be accepted on the edge after the last CRC byte is loaded.
- No idle cycle is otherwise inserted.
REQ-025 The CRC update is a full 8-bit-per-cycle parallel computation with no multi-cycle iteration.

Reset
REQ-026 Assertion of rst_n=0 asynchronously forces state=PASS, crc=INIT, m_valid=0, m_last=0, m_data=0, byte index=0.
REQ-027 During reset, s_ready=0.
REQ-028 Reset mid-frame discards the frame; no partial CRC is emitted after release.
REQ-029 Deassertion of reset is assumed synchronised externally.

Configuration
REQ-030 Macro CRC_STREAM_CHECK_EN, when defined, adds:
- input chk_mode (1 bit, sampled on the first byte of each frame);
- outputs chk_done (1 bit) and chk_err (1 bit);
- parameter RESIDUE (default 0).
REQ-031 With the macro defined and chk_mode=1, the frame (payload plus received CRC) is forwarded unchanged.
- m_last follows s_last.
- No bytes are appended and APPEND is never entered.
REQ-032 In check mode, on the edge after the s_last byte is accepted, the block shall pulse chk_done=1 for one cycle.
- chk_err = (crc_final != RESIDUE), where crc_final is the CRC over all frame bytes before XOR_OUT.
REQ-033 Without the macro, the ports, parameter and logic are absent, and behaviour is generate-only.

Structure
REQ-034 Package crc_pkg holds:
- the state enum (PASS, APPEND);
- function reflect8;
- a function computing the byte-parallel CRC update from CRC_W and POLY.
REQ-035 Sub-module crc_core (combinational: crc_in, data, crc_out) implements the update.
- crc_stream holds the FSM, handshake and output register.

Verification
REQ-036 CRC_W=8, POLY=07, INIT=00, XOR_OUT=00, REFLECT=0: stream "123456789" -> payload echoed, then F4 with m_last.
REQ-037 CRC_W=16, POLY=1021, INIT=FFFF, XOR_OUT=0: "123456789" -> payload echoed, then 29, B1.
REQ-038 CRC_W=32, POLY=04C11DB7, INIT=FFFFFFFF, XOR_OUT=FFFFFFFF, REFLECT=1: "123456789" -> payload echoed, then 26 39 F4 CB.
REQ-039 CRC-8 config, m_ready randomly low 50% during payload and APPEND, two back-to-back frames -> both CRCs F4, no dropped/duplicated bytes, m_data stable under stall.
REQ-040 rst_n pulsed low mid-payload, then frame "123456789" -> outputs clear immediately, subsequent CRC F4 (INIT reloaded).
REQ-041 CRC_STREAM_CHECK_EN, chk_mode=1, CRC-8 config: "123456789" F4 -> chk_done=1, chk_err=0; with last byte F5 -> chk_err=1.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared types and helpers for the streaming CRC block.
// Holds the two-state FSM encoding, a byte bit-reversal helper and the
// byte-parallel CRC update used by crc_core.
package crc_pkg;

    // Frame phase: forwarding payload, or appending the CRC bytes.
    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_e;

    // Widest CRC supported; narrower CRCs live in the low bits.
    localparam int unsigned CRC_MAX_W = 32;

    // Bit-reverse one byte (LSB-first data into the MSB-first update).
    function automatic logic [7:0] reflect8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    // One byte folded into a normal-form (MSB-first) CRC of width w.
    // The eight bit steps are unrolled, so this is purely combinational.
    // Results are masked to w bits; the upper bits are always zero.
    function automatic logic [CRC_MAX_W-1:0] crc_byte_update(
        input int                   w,
        input logic [CRC_MAX_W-1:0] poly,
        input logic [CRC_MAX_W-1:0] crc,
        input logic [7:0]           data
    );
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] c;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        c    = (crc ^ ({24'd0, data} << (w - 8))) & mask;
        for (int b = 0; b < 8; b++) begin
            if (c[w-1]) begin
                c = ((c << 1) ^ poly) & mask;
            end else begin
                c = (c << 1) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_core.sv
// crc_core: combinational byte-parallel CRC update, crc_out = f(crc_in, data).
module crc_core
    import crc_pkg::*;
#(
    parameter int unsigned       CRC_W = 8,
    parameter logic [CRC_W-1:0]  POLY  = 8'h07
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_MAX_W-1:0] upd_full;

    // Whole byte folded in a single combinational step.
    always_comb begin
        upd_full = crc_byte_update(CRC_W, CRC_MAX_W'(POLY), CRC_MAX_W'(crc_in), data);
    end

    assign crc_out = upd_full[CRC_W-1:0];

    // Bits above CRC_W are masked to zero by the update and carry nothing.
    generate
        if (CRC_W < CRC_MAX_W) begin : g_pad
            logic [CRC_MAX_W-1-CRC_W:0] pad_unused;
            assign pad_unused = upd_full[CRC_MAX_W-1:CRC_W];
        end
    endgenerate

endmodule

// File: rtl/crc_stream.sv
// crc_stream: byte stream pass-through that appends a CRC after each frame.
// Payload is forwarded through one output register; after the s_last byte
// the CRC_W/8 bytes of (crc ^ XOR_OUT) follow, the final one with m_last.
// Optional build macro CRC_STREAM_CHECK_EN adds a check mode (chk_mode,
// chk_done, chk_err, RESIDUE) in which frames are forwarded untouched and the
// CRC over payload plus received CRC is compared against RESIDUE.
module crc_stream
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b0
`ifdef CRC_STREAM_CHECK_EN
    ,
    parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last
`ifdef CRC_STREAM_CHECK_EN
    ,
    input  logic       chk_mode,
    output logic       chk_done,
    output logic       chk_err
`endif
);

    localparam int unsigned NBYTES   = CRC_W / 8;
    localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [1:0]       idx_q, idx_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;

    logic             load;
    logic             s_fire;
    logic             crc_done;
    logic             check_frame;
    logic [7:0]       core_data;
    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] crc_view;
    logic [CRC_W-1:0] crc_tx;
    logic [7:0]       crc_bytes [4];
    logic [1:0]       sel;

    // The output register may take a new byte when empty or being drained.
    assign load    = !m_valid_q || m_ready;
    assign s_ready = rst_n && (state_q == PASS) && load;
    assign s_fire  = s_valid && s_ready;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

    // Reflected mode feeds LSB-first bytes into the MSB-first update.
    assign core_data = REFLECT ? reflect8(s_data) : s_data;

    crc_core #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_core (
        .crc_in  (crc_q),
        .data    (core_data),
        .crc_out (crc_next)
    );

    // Output view of the CRC register: bit-reversed when REFLECT is set.
    generate
        for (genvar gi = 0; gi < CRC_W; gi++) begin : g_view
            assign crc_view[gi] = REFLECT ? crc_q[CRC_W-1-gi] : crc_q[gi];
        end
    endgenerate

    assign crc_tx = crc_view ^ XOR_OUT;

    // Split the transmitted CRC into bytes; slot 0 is the least significant.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            if (gi < NBYTES) begin : g_used
                assign crc_bytes[gi] = crc_tx[gi*8 +: 8];
            end else begin : g_zero
                assign crc_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    // Reflected CRCs go out LSB byte first, normal ones MSB byte first.
    assign sel      = REFLECT ? idx_q : (LAST_IDX - idx_q);
    assign crc_done = (idx_q == LAST_IDX);

`ifdef CRC_STREAM_CHECK_EN
    logic             first_q, first_d;
    logic             mode_q, mode_d;
    logic             chk_done_q, chk_done_d;
    logic             chk_err_q, chk_err_d;
    logic [CRC_W-1:0] crc_next_view;

    // chk_mode is honoured on the first byte and held for the rest of the frame.
    assign check_frame = first_q ? chk_mode : mode_q;
    assign chk_done    = chk_done_q;
    assign chk_err     = chk_err_q;

    generate
        for (genvar gi = 0; gi < CRC_W; gi++) begin : g_next_view
            assign crc_next_view[gi] = REFLECT ? crc_next[CRC_W-1-gi] : crc_next[gi];
        end
    endgenerate

    // Check-mode bookkeeping: frame start tracking and the one-cycle verdict.
    always_comb begin
        first_d    = first_q;
        mode_d     = mode_q;
        chk_done_d = 1'b0;
        chk_err_d  = 1'b0;
        if (s_fire) begin
            first_d = s_last;
            mode_d  = check_frame;
            if (s_last && check_frame) begin
                chk_done_d = 1'b1;
                chk_err_d  = (crc_next_view != RESIDUE);
            end
        end
    end

    // Check-mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q    <= 1'b1;
            mode_q     <= 1'b0;
            chk_done_q <= 1'b0;
            chk_err_q  <= 1'b0;
        end else begin
            first_q    <= first_d;
            mode_q     <= mode_d;
            chk_done_q <= chk_done_d;
            chk_err_q  <= chk_err_d;
        end
    end
`else
    assign check_frame = 1'b0;
`endif

    // Next state: enter APPEND after a generating frame's last byte,
    // return to PASS once the last CRC byte is loaded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS: begin
                if (s_fire && s_last && !check_frame) begin
                    state_d = APPEND;
                end
            end
            APPEND: begin
                if (load && crc_done) begin
                    state_d = PASS;
                end
            end
        endcase
    end

    // Datapath: CRC accumulation, byte index and output register loading.
    always_comb begin
        crc_d     = crc_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        case (state_q)
            PASS: begin
                if (s_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_last_d  = check_frame && s_last;
                    crc_d     = (check_frame && s_last) ? INIT : crc_next;
                    idx_d     = '0;
                end
            end
            APPEND: begin
                if (load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = crc_bytes[sel];
                    m_last_d  = crc_done;
                    if (crc_done) begin
                        crc_d = INIT;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
        endcase
    end

    // State, CRC and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PASS;
            crc_q     <= INIT;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: three crc_stream instances (CRC-8, CRC-16/CCITT-FALSE,
// CRC-32) driven one at a time. Known-answer vectors come from a table;
// random frames are checked against a bit-serial reference model.
// Check-mode tests are included when CRC_STREAM_CHECK_EN is defined.
module tb_crc_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid [3];
    logic       s_last  [3];
    logic [7:0] s_data  [3];
    logic       s_ready [3];
    logic       m_valid [3];
    logic       m_ready [3];
    logic [7:0] m_data  [3];
    logic       m_last  [3];
`ifdef CRC_STREAM_CHECK_EN
    logic       chk_mode [3];
    logic       chk_done [3];
    logic       chk_err  [3];
`endif

    int   checks     = 0;
    int   failures   = 0;
    int   cur        = 0;
    bit   mon_en     = 1'b0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int   cyc        = 0;
    int   acc_first;
    int   acc_last;

    logic [8:0] exp_q [$];
    logic [7:0] pay   [$];

    typedef struct {
        int         k;
        int         nb;
        logic [7:0] b [4];
    } vec_t;
    vec_t vecs [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_stream #(
        .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .REFLECT(1'b0)
    ) u_crc8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0])
`ifdef CRC_STREAM_CHECK_EN
        , .chk_mode(chk_mode[0]), .chk_done(chk_done[0]), .chk_err(chk_err[0])
`endif
    );

    crc_stream #(
        .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .REFLECT(1'b0)
    ) u_crc16 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1])
`ifdef CRC_STREAM_CHECK_EN
        , .chk_mode(chk_mode[1]), .chk_done(chk_done[1]), .chk_err(chk_err[1])
`endif
    );

    crc_stream #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b1)
    ) u_crc32 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]), .s_last(s_last[2]),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_last(m_last[2])
`ifdef CRC_STREAM_CHECK_EN
        , .chk_mode(chk_mode[2]), .chk_done(chk_done[2]), .chk_err(chk_err[2])
`endif
    );

    // ---------------- reference model ----------------
    function automatic int cfg_w(input int k);
        return (k == 0) ? 8 : (k == 1) ? 16 : 32;
    endfunction
    function automatic logic [31:0] cfg_poly(input int k);
        return (k == 0) ? 32'h07 : (k == 1) ? 32'h1021 : 32'h04C11DB7;
    endfunction
    function automatic logic [31:0] cfg_init(input int k);
        return (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF : 32'hFFFFFFFF;
    endfunction
    function automatic logic [31:0] cfg_xor(input int k);
        return (k == 2) ? 32'hFFFFFFFF : 32'h0;
    endfunction
    function automatic bit cfg_refl(input int k);
        return (k == 2);
    endfunction

    function automatic logic [31:0] refl_w(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Normal configs: message shifted in one bit at a time, MSB first.
    // Reflected configs: classic right-shifting algorithm with reversed poly.
    function automatic logic [31:0] model_crc(input int k);
        int          w;
        logic [31:0] mask, crc, rp;
        logic        fb;
        w    = cfg_w(k);
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        if (!cfg_refl(k)) begin
            crc = cfg_init(k);
            foreach (pay[i]) begin
                for (int b = 7; b >= 0; b--) begin
                    fb  = crc[w-1] ^ pay[i][b];
                    crc = (crc << 1) & mask;
                    if (fb) crc = crc ^ cfg_poly(k);
                end
            end
        end else begin
            rp  = refl_w(cfg_poly(k), w);
            crc = refl_w(cfg_init(k), w);
            foreach (pay[i]) begin
                crc = crc ^ {24'd0, pay[i]};
                for (int b = 0; b < 8; b++) begin
                    if (crc[0]) crc = (crc >> 1) ^ rp;
                    else        crc = crc >> 1;
                end
            end
        end
        return (crc ^ cfg_xor(k)) & mask;
    endfunction

    task automatic push_payload_exp();
        foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
    endtask

    task automatic push_model_exp(input int k);
        logic [31:0] res;
        int          nb, p;
        res = model_crc(k);
        nb  = cfg_w(k) / 8;
        for (int j = 0; j < nb; j++) begin
            p = cfg_refl(k) ? j : (nb - 1 - j);
            exp_q.push_back({(j == nb - 1), res[p*8 +: 8]});
        end
    endtask

    task automatic push_vec_exp(input int v);
        for (int j = 0; j < vecs[v].nb; j++)
            exp_q.push_back({(j == vecs[v].nb - 1), vecs[v].b[j]});
    endtask

    task automatic load_msg();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
    endtask

    // ---------------- drivers ----------------
    task automatic send_frame(input int k, input int gap_max);
        bit got;
        int budget;
        for (int i = 0; i < pay.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
            s_valid[k] = 1'b1;
            s_data[k]  = pay[i];
            s_last[k]  = (i == pay.size() - 1);
            got        = 1'b0;
            budget     = 0;
            while (!got && budget < 500) begin
                @(negedge clk);
                got = (s_ready[k] === 1'b1);
                @(posedge clk); #1;
                budget++;
            end
            s_valid[k] = 1'b0;
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout inst=%0d byte=%0d got no s_ready required accept within 500 cycles", k, i);
                return;
            end
            if (i == 0) acc_first = cyc;
            acc_last = cyc;
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || m_valid[cur] === 1'b1) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout inst=%0d got %0d bytes missing required 0", cur, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            for (int k = 0; k < 3; k++)
                m_ready[k] = (ready_mode == 0) ? 1'b1 :
                             (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        bit         hold_pend;
        logic [8:0] hold_val;
        logic [8:0] e;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst_n !== 1'b1) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    checks++;
                    if (m_valid[cur] !== 1'b1 || {m_last[cur], m_data[cur]} !== hold_val) begin
                        failures++;
                        $display("FAIL stall_hold inst=%0d got valid=%0b data=%02h last=%0b required valid=1 data=%02h last=%0b",
                                 cur, m_valid[cur], m_data[cur], m_last[cur], hold_val[7:0], hold_val[8]);
                    end
                end
                if (m_valid[cur] === 1'b1 && m_ready[cur] === 1'b1) begin
                    hold_pend = 1'b0;
                    checks++;
                    $display("xfer inst=%0d data=%02h last=%0b", cur, m_data[cur], m_last[cur]);
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_byte inst=%0d got data=%02h last=%0b required no byte",
                                 cur, m_data[cur], m_last[cur]);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last[cur], m_data[cur]} !== e) begin
                            failures++;
                            $display("FAIL out_byte inst=%0d got data=%02h last=%0b required data=%02h last=%0b",
                                     cur, m_data[cur], m_last[cur], e[7:0], e[8]);
                        end
                    end
                end else if (m_valid[cur] === 1'b1) begin
                    hold_pend = 1'b1;
                    hold_val  = {m_last[cur], m_data[cur]};
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got timeout required end of test");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int l, nb, len;
        vecs[0].k = 0; vecs[0].nb = 1; vecs[0].b = '{8'hF4, 8'h00, 8'h00, 8'h00};
        vecs[1].k = 1; vecs[1].nb = 2; vecs[1].b = '{8'h29, 8'hB1, 8'h00, 8'h00};
        vecs[2].k = 2; vecs[2].nb = 4; vecs[2].b = '{8'h26, 8'h39, 8'hF4, 8'hCB};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = 8'h00; m_ready[k] = 1'b1;
`ifdef CRC_STREAM_CHECK_EN
            chk_mode[k] = 1'b0;
`endif
        end

        // Reset state, with s_ready held low while in reset.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s_ready[k], m_valid[k], m_last[k], m_data[k]} !== 11'h000) begin
                failures++;
                $display("FAIL reset_state inst=%0d got s_ready=%0b m_valid=%0b m_last=%0b m_data=%02h required all 0",
                         k, s_ready[k], m_valid[k], m_last[k], m_data[k]);
            end
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Known-answer "123456789" vectors, without and then with stalls.
        for (int p = 0; p < 2; p++) begin
            ready_mode = p;
            for (int v = 0; v < 3; v++) begin
                cur = vecs[v].k;
                load_msg();
                push_payload_exp();
                push_vec_exp(v);
                send_frame(vecs[v].k, p);
                wait_drain();
            end
        end

        // Two back-to-back CRC-8 frames under random output stalls.
        cur = 0;
        ready_mode = 1;
        load_msg(); push_payload_exp(); push_vec_exp(0);
        load_msg(); push_payload_exp(); push_vec_exp(0);
        load_msg(); send_frame(0, 0);
        load_msg(); send_frame(0, 0);
        wait_drain();

        // Random frames of 1..12 bytes against the reference model.
        for (int k = 0; k < 3; k++) begin
            cur = k;
            for (int f = 0; f < 6; f++) begin
                len = $urandom_range(1, 12);
                pay.delete();
                for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
                push_payload_exp();
                push_model_exp(k);
                send_frame(k, 2);
            end
            wait_drain();
        end

        // Single-byte frame followed immediately by the next frame:
        // the next first byte is accepted right after the last CRC byte loads.
        ready_mode = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k += 2) begin
            cur = k;
            nb  = cfg_w(k) / 8;
            pay.delete(); pay.push_back(8'h5A);
            push_payload_exp(); push_model_exp(k);
            send_frame(k, 0);
            l = acc_last;
            pay.delete(); pay.push_back(8'hC3); pay.push_back(8'h11);
            push_payload_exp(); push_model_exp(k);
            send_frame(k, 0);
            checks++;
            if (acc_first - l != nb + 1) begin
                failures++;
                $display("FAIL back_to_back inst=%0d got gap=%0d cycles required %0d", k, acc_first - l, nb + 1);
            end
            wait_drain();
        end

        // Reset pulsed mid-frame: outputs clear at once, INIT reloaded.
        cur = 0;
        mon_en = 1'b0;
        ready_mode = 2;
        @(posedge clk); #3;
        pay.delete(); pay.push_back(8'hAA);
        send_frame(0, 0);
        #2;
        checks++;
        if (m_valid[0] !== 1'b1 || m_data[0] !== 8'hAA) begin
            failures++;
            $display("FAIL pre_reset_hold got m_valid=%0b m_data=%02h required m_valid=1 m_data=aa", m_valid[0], m_data[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready[0], m_valid[0], m_last[0], m_data[0]} !== 11'h000) begin
            failures++;
            $display("FAIL async_reset got s_ready=%0b m_valid=%0b m_last=%0b m_data=%02h required all 0",
                     s_ready[0], m_valid[0], m_last[0], m_data[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        mon_en = 1'b1;
        load_msg(); push_payload_exp(); push_vec_exp(0);
        send_frame(0, 0);
        wait_drain();

`ifdef CRC_STREAM_CHECK_EN
        // Check mode: frame plus received CRC forwarded, verdict pulsed once.
        cur = 0;
        for (int t = 0; t < 2; t++) begin
            logic exp_err;
            exp_err = (t == 1);
            chk_mode[0] = 1'b1;
            load_msg();
            pay.push_back((t == 0) ? 8'hF4 : 8'hF5);
            foreach (pay[i]) exp_q.push_back({(i == pay.size() - 1), pay[i]});
            send_frame(0, 0);
            checks++;
            if (chk_done[0] !== 1'b1 || chk_err[0] !== exp_err) begin
                failures++;
                $display("FAIL chk_verdict t=%0d got done=%0b err=%0b required done=1 err=%0b",
                         t, chk_done[0], chk_err[0], exp_err);
            end
            @(posedge clk); #1;
            checks++;
            if (chk_done[0] !== 1'b0) begin
                failures++;
                $display("FAIL chk_pulse t=%0d got done=%0b required 0", t, chk_done[0]);
            end
            chk_mode[0] = 1'b0;
            wait_drain();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
